// File: rtl/seg_scan_mux.sv
`timescale 1ns/1ps
// seg_scan_mux: time-multiplexes DIGITS hex nibbles onto one shared
// active-low seven-segment bus. It includes a refresh prescaler, hex decode,
// per-digit decimal points, leading-zero suppression and a dark gap
// between digits.
module seg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                r,
  input  logic                en,
  input  logic [4*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          sseg,
  output logic                dp,
  output logic                frame_done
);

  localparam int MAXV = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [CW-1:0] LIT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {GAP, LIT} state_t;

  // With no blanking gap, every digit begins directly in its lit phase.
  localparam state_t FIRST_PHASE = (BLANK_CYCLES == 0) ? LIT : GAP;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q, run_d;
  logic [4*DIGITS-1:0] snapDigits_q, snapDigits_d;
  logic [DIGITS-1:0]   snapDp_q, snapDp_d;
  logic                snapLz_q, snapLz_d;
  logic                frameDone_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          sseg_q, sseg_d;
  logic                dp_q, dp_d;
  logic                frameDone_q;
  logic [DIGITS-1:0]   zeroFrom;
  logic [3:0]          nibble;
  logic                blank;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Scan sequencing: restart on enable, gap/lit timing, digit advance,
  // and a fresh input snapshot whenever digit 0 begins a new frame.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    snapDigits_d = snapDigits_q;
    snapDp_d     = snapDp_q;
    snapLz_d     = snapLz_q;
    frameDone_d  = 1'b0;
    if (!en) begin
      state_d = GAP;
      idx_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b0;
    end else if (!run_q) begin
      run_d        = 1'b1;
      state_d      = FIRST_PHASE;
      idx_d        = '0;
      cnt_d        = '0;
      snapDigits_d = digits;
      snapDp_d     = dp_mask;
      snapLz_d     = lz_en;
    end else begin
      case (state_q)
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = LIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LIT: begin
          if (cnt_q == LIT_LAST) begin
            state_d = FIRST_PHASE;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              frameDone_d  = 1'b1;
              snapDigits_d = digits;
              snapDp_d     = dp_mask;
              snapLz_d     = lz_en;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = GAP;
      endcase
    end
  end

  // zeroFrom[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    zeroFrom = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zeroFrom[i] = ((snapDigits_d >> (4 * i)) == '0);
    end
  end

  // The output image is computed from the next state so that the registered
  // pins change on the same edge as the state they reflect.
  always_comb begin
    an_d   = '1;
    sseg_d = 7'h7F;
    dp_d   = 1'b1;
    nibble = snapDigits_d[4*int'(idx_d) +: 4];
    blank  = snapLz_d && (idx_d != '0) && zeroFrom[idx_d];
    if (state_d == LIT) begin
      an_d = ~(DIGITS'(1) << idx_d);
      dp_d = ~snapDp_d[idx_d];
      if (!blank) begin
        sseg_d = hexToSeg(nibble);
      end
    end
  end

  // State, snapshot and output registers; reset forces the display dark at once.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q      <= GAP;
      idx_q        <= '0;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      snapDigits_q <= '0;
      snapDp_q     <= '0;
      snapLz_q     <= 1'b0;
      an_q         <= '1;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      snapDigits_q <= snapDigits_d;
      snapDp_q     <= snapDp_d;
      snapLz_q     <= snapLz_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      frameDone_q  <= frameDone_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
`timescale 1ns/1ps
// Testbench for seg_scan_mux. It drives two instances from shared stimulus:
// a 4-digit instance with a gap, and an 8-digit instance with no gap.
module tb_seg_scan_mux;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        r;
  logic        en;
  logic        lz;
  logic [15:0] dIn1;
  logic [3:0]  dpIn1;
  logic [31:0] dIn2;
  logic [7:0]  dpIn2;

  logic [3:0]  an1;
  logic [6:0]  sseg1;
  logic        dpo1;
  logic        fd1;
  logic [7:0]  an2;
  logic [6:0]  sseg2;
  logic        dpo2;
  logic        fd2;

  int checks = 0;
  int errors = 0;

  exp_t q1[$];
  exp_t q2[$];

  bit          act1, act2;
  int          t1, t2;
  logic [31:0] sd1, sd2;
  logic [7:0]  sdp1, sdp2;
  bit          slz1, slz2;

  seg_scan_mux #(.DIGITS(4), .TICK_DIV(4), .BLANK_CYCLES(1)) dut1 (
    .clk(clk), .r(r), .en(en), .digits(dIn1), .dp_mask(dpIn1), .lz_en(lz),
    .an(an1), .sseg(sseg1), .dp(dpo1), .frame_done(fd1)
  );

  seg_scan_mux #(.DIGITS(8), .TICK_DIV(1), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .r(r), .en(en), .digits(dIn2), .dp_mask(dpIn2), .lz_en(lz),
    .an(an2), .sseg(sseg2), .dp(dpo2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Timeline model: t counts edges since the scan (re)started. Digit and
  // phase follow from division by the digit period; inputs are latched
  // at every frame boundary.
  task automatic stepModel(input int D, input int TK, input int BL, input bit enI,
                           input logic [31:0] din, input logic [7:0] dpin, input bit lzin,
                           inout bit act, inout int t, inout logic [31:0] sd,
                           inout logic [7:0] sdp, inout bit slz, output exp_t e);
    int P, F, d;
    logic [31:0] hi;
    bit fd;
    P  = TK + BL;
    F  = D * P;
    fd = 1'b0;
    if (!enI) begin
      act = 1'b0;
    end else if (!act) begin
      act = 1'b1; t = 0; sd = din; sdp = dpin; slz = lzin;
    end else begin
      t++;
      if (t % F == 0) begin
        fd = 1'b1; sd = din; sdp = dpin; slz = lzin;
      end
    end
    e.an = 8'hFF; e.sseg = 7'h7F; e.dp = 1'b1; e.fd = fd;
    if (act && (t % P) >= BL) begin
      d    = (t / P) % D;
      e.an = ~(8'd1 << d);
      e.dp = ~sdp[d];
      hi   = sd >> (4 * d);
      if (!(slz && d > 0 && hi == 32'd0)) e.sseg = segOf(sd[4*d +: 4]);
    end
    e.an = e.an & 8'((1 << D) - 1);
  endtask

  task automatic checkOutput(input string name, input exp_t e, input logic [7:0] a,
                             input logic [6:0] s, input logic d, input logic f);
    checks++;
    if (a !== e.an || s !== e.sseg || d !== e.dp || f !== e.fd) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got an=%b sseg=%b dp=%b fd=%b, expected an=%b sseg=%b dp=%b fd=%b",
               name, $time, a, s, d, f, e.an, e.sseg, e.dp, e.fd);
    end
  endtask

  // One clock of stimulus: predict the result of the coming edge, then
  // queue the predictions for the monitor.
  task automatic applyStimulus();
    exp_t e1, e2;
    stepModel(4, 4, 1, en, {16'h0, dIn1}, {4'h0, dpIn1}, lz, act1, t1, sd1, sdp1, slz1, e1);
    stepModel(8, 1, 0, en, dIn2, dpIn2, lz, act2, t2, sd2, sdp2, slz2, e2);
    @(posedge clk);
    q1.push_back(e1);
    q2.push_back(e2);
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic waitDigit(input int k);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (act1 && (t1 % 5) >= 1 && ((t1 / 5) % 4) == k) found = 1'b1;
      else applyStimulus();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL waitDigit%0d: digit not reached within 40 cycles, expected it to be reached", k);
    end
  endtask

  task automatic checkDark(input string name);
    exp_t e1, e2;
    e1 = '{an: 8'h0F, sseg: 7'h7F, dp: 1'b1, fd: 1'b0};
    e2 = '{an: 8'hFF, sseg: 7'h7F, dp: 1'b1, fd: 1'b0};
    checkOutput({name, "_d1"}, e1, {4'h0, an1}, sseg1, dpo1, fd1);
    checkOutput({name, "_d2"}, e2, an2, sseg2, dpo2, fd2);
  endtask

  // Monitor: compare each queued prediction against the pins away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("dut1", e, {4'h0, an1}, sseg1, dpo1, fd1);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      checkOutput("dut2", e, an2, sseg2, dpo2, fd2);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence: directed scenarios first, then randomized blocks.
  initial begin
    int k1, k2;
    r = 1'b0; en = 1'b1; lz = 1'b0;
    dIn1 = 16'h1234; dpIn1 = 4'h0;
    dIn2 = 32'h89AB_CDEF; dpIn2 = 8'h01;
    act1 = 0; act2 = 0; t1 = 0; t2 = 0;
    sd1 = '0; sd2 = '0; sdp1 = '0; sdp2 = '0; slz1 = 0; slz2 = 0;
    repeat (3) @(posedge clk);
    #1;
    checkDark("reset");
    @(negedge clk);
    r = 1'b1;

    $display("[TB] plain scan 1234");
    runCycles(45);

    $display("[TB] leading-zero suppression");
    lz = 1'b1; dIn1 = 16'h0050; dIn2 = 32'h0000_0050;
    runCycles(45);
    dIn1 = 16'h0000; dIn2 = 32'h0000_0000; dpIn1 = 4'b1010; dpIn2 = 8'hA5;
    runCycles(45);

    $display("[TB] mid-frame input change");
    lz = 1'b0; dpIn1 = 4'b0100; dIn1 = 16'h1111; dIn2 = 32'h1111_1111;
    runCycles(25);
    waitDigit(2);
    dIn1 = 16'h2222; dIn2 = 32'h2222_2222;
    runCycles(45);

    $display("[TB] enable outage");
    waitDigit(2);
    en = 1'b0;
    runCycles(3);
    en = 1'b1;
    runCycles(30);

    $display("[TB] asynchronous reset mid-lit");
    waitDigit(1);
    @(negedge clk);
    #1 r = 1'b0;
    #0.5 checkDark("async_reset");
    #0.5 r = 1'b1;
    act1 = 0; act2 = 0;
    runCycles(25);

    $display("[TB] randomized blocks");
    for (int b = 0; b < 40; b++) begin
      k1 = $urandom_range(0, 4);
      k2 = $urandom_range(0, 8);
      dIn1  = 16'($urandom & ((32'd1 << (4 * k1)) - 32'd1));
      dIn2  = 32'(longint'($urandom) & ((64'd1 << (4 * k2)) - 64'd1));
      dpIn1 = 4'($urandom);
      dpIn2 = 8'($urandom);
      lz    = 1'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      runCycles(en ? $urandom_range(5, 40) : $urandom_range(1, 4));
    end
    en = 1'b1;
    runCycles(20);

    @(negedge clk);
    #1;
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d/%0d predictions left unchecked, expected 0", q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
